// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its queue.
// Holds the fetch FSM encoding, the queue entry layout and a word-alignment helper.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO buffering fetched {pc, instr} pairs between the fetch unit and decode.
// Flush empties the queue and overrides any same-cycle push or pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  fq_entry_t                push_entry_i,
  input  logic                     pop_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     head_valid_o,
  output fq_entry_t                head_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q,  count_d;
  fq_entry_t     entries_q [DEPTH];

  logic do_push;
  logic do_pop;

  assign do_push = push_i && !flush_i && (count_q != FULL_CNT || do_pop);
  assign do_pop  = pop_i && !flush_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (do_push && !do_pop)      count_d = count_q + (PW + 1)'(1);
      else if (do_pop && !do_push) count_d = count_q - (PW + 1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset; the head is masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (do_push) entries_q[wr_ptr_q] <= push_entry_i;
  end

  assign count_o      = count_q;
  assign head_valid_o = (count_q != '0);

  always_comb begin
    head_o.pc    = 32'h0;
    head_o.instr = NOP_INSTR;
    if (count_q != '0) head_o = entries_q[rd_ptr_q];
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one MMU read at a time and queues results
// for decode; redirects arriving during a miss are parked until the MMU access completes.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addy,
  output logic        imem_ren,
  output logic        imem_wen,
  output logic [3:0]  imem_byte_sel,
  input  logic        imem_nostall,
  input  logic [31:0] imem_dataout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  target_q, target_d;

  logic [CW-1:0] q_count;
  logic          q_valid;
  fq_entry_t     q_head;
  fq_entry_t     push_entry;
  logic          q_push;
  logic          q_flush;
  logic          q_pop;
  logic [31:0]   redir_pc;

  assign redir_pc      = align_word(redirect_pc);
  assign imem_addy     = pc_q;
  assign imem_wen      = 1'b0;
  assign imem_byte_sel = 4'b1111;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    target_d = target_q;
    q_push   = 1'b0;
    q_flush  = 1'b0;
    imem_ren = 1'b0;
    // A full queue blocks issue even if decode pops this cycle.
    if (reset) imem_ren = (state_q == DRAIN) ? 1'b1 : (q_count < FULL_CNT);

    case (state_q)
      RUN: begin
        if (redirect_valid) begin
          q_flush = 1'b1;
          if (imem_ren && !imem_nostall) begin
            target_d = redir_pc;
            state_d  = DRAIN;
          end else begin
            pc_d = redir_pc;
          end
        end else if (imem_ren && imem_nostall) begin
          q_push = 1'b1;
          pc_d   = pc_q + 32'd4;
        end
      end
      DRAIN: begin
        if (redirect_valid) begin
          q_flush  = 1'b1;
          target_d = redir_pc;
        end
        // The wrong-path word completing here is dropped; only the PC moves.
        if (imem_nostall) begin
          pc_d    = redirect_valid ? redir_pc : target_q;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      target_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      target_q <= target_d;
    end
  end

  assign push_entry.pc    = pc_q;
  assign push_entry.instr = imem_dataout;
  assign q_pop            = q_valid && out_ready;

  fetch_queue #(
    .DEPTH(QDEPTH)
  ) u_queue (
    .clk          (clk),
    .rst_n        (reset),
    .flush_i      (q_flush),
    .push_i       (q_push),
    .push_entry_i (push_entry),
    .pop_i        (q_pop),
    .count_o      (q_count),
    .head_valid_o (q_valid),
    .head_o       (q_head)
  );

  assign out_valid = q_valid;
  assign out_instr = q_head.instr;
  assign out_pc    = q_head.pc;

endmodule
